// File: rtl/dmem_access_arbiter.sv
// dmem_access_arbiter
//   Shares the single Data_Memory port between two requesters:
//   m0 is the core load/store stage and m1 is the debug/loader port.
//   The winner's request is latched and driven onto the memory port as registered
//   strobes. Read data, which the memory returns one cycle later, is routed back
//   to the winner. Addresses at or above DEPTH are rejected: no strobe is issued,
//   and an err pulse is returned instead.
//
//   Build option: define DMEM_ARB_RR_EN for round-robin arbitration on contention.
//   When it is left undefined, m0 has fixed priority.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   mX_req/we/addr/wdata  requester X (0,1); fields held until mX_gnt
//   mX_gnt                1-cycle pulse when the request is issued
//   mX_rvalid/mX_rdata    1-cycle read response; rdata is 0 when rvalid is low
//   mX_err                1-cycle pulse on an out-of-range access
//   mem_addr/wdata        registered address/data to Data_Memory (hold last issue)
//   mem_write/mem_read    registered 1-cycle strobes to Data_Memory
//   mem_rdata             Data_Memory read data (1-cycle latency)
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | arbitrate; latch the winner's fields on any request
// ISSUE  | gnt pulse, memory strobe (in range), write error reported here
// RESP   | read only: rvalid with memory data, or rdata=0 + err if out of range
module dmem_access_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    // One extra bit so that a DEPTH of 2**ADDR_W does not wrap to zero.
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    state_t              state_q, state_d;
    logic                winner_q, winner_d;   // 0 = m0, 1 = m1
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                err0_q, err0_d, err1_q, err1_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_write_q, mem_write_d;
    logic                mem_read_q, mem_read_d;
`ifdef DMEM_ARB_RR_EN
    logic                last_winner_q, last_winner_d;
`endif

    logic                pick_m1;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_oor;

    always_comb begin
`ifdef DMEM_ARB_RR_EN
        if (m0_req && m1_req) begin
            pick_m1 = !last_winner_q;
        end else begin
            pick_m1 = !m0_req;
        end
`else
        pick_m1 = !m0_req;
`endif
        sel_we    = pick_m1 ? m1_we    : m0_we;
        sel_addr  = pick_m1 ? m1_addr  : m0_addr;
        sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
        sel_oor   = ({1'b0, sel_addr} >= DEPTH_EXT);
    end

    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        we_d        = we_q;
        oor_d       = oor_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        err0_d      = 1'b0;
        err1_d      = 1'b0;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_winner_d = last_winner_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    state_d     = S_ISSUE;
                    winner_d    = pick_m1;
                    we_d        = sel_we;
                    oor_d       = sel_oor;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_write_d = sel_we && !sel_oor;
                    mem_read_d  = !sel_we && !sel_oor;
                    gnt0_d      = !pick_m1;
                    gnt1_d      = pick_m1;
                    // An out-of-range write has no response phase, so its error
                    // is reported alongside the grant.
                    err0_d      = sel_we && sel_oor && !pick_m1;
                    err1_d      = sel_we && sel_oor && pick_m1;
`ifdef DMEM_ARB_RR_EN
                    last_winner_d = pick_m1;
`endif
                end
            end
            S_ISSUE: begin
                if (we_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_RESP;
                    rvalid0_d = !winner_q;
                    rvalid1_d = winner_q;
                    err0_d    = oor_q && !winner_q;
                    err1_d    = oor_q && winner_q;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            winner_q    <= 1'b0;
            we_q        <= 1'b0;
            oor_q       <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_winner_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            we_q        <= we_d;
            oor_q       <= oor_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            err0_q      <= err0_d;
            err1_q      <= err1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
`ifdef DMEM_ARB_RR_EN
            last_winner_q <= last_winner_d;
`endif
        end
    end

    // Pulses are masked while reset is high. Without the mask, a read that is in
    // flight when reset arrives would still show rvalid in that same cycle.
    assign m0_gnt    = gnt0_q    && !reset;
    assign m1_gnt    = gnt1_q    && !reset;
    assign m0_rvalid = rvalid0_q && !reset;
    assign m1_rvalid = rvalid1_q && !reset;
    assign m0_err    = err0_q    && !reset;
    assign m1_err    = err1_q    && !reset;
    assign mem_write = mem_write_q && !reset;
    assign mem_read  = mem_read_q  && !reset;

    // Out-of-range reads never strobed the memory, so its data bus is not passed on.
    assign m0_rdata  = (m0_rvalid && !oor_q) ? mem_rdata : '0;
    assign m1_rdata  = (m1_rvalid && !oor_q) ? mem_rdata : '0;

    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_arbiter.sv
module tb_dmem_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write, mem_read;

    dmem_access_arbiter #(.ADDR_W(32), .DATA_W(32), .DEPTH(2048)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural Data_Memory with 1-cycle read latency; known contents loaded in reset.
    logic [31:0] dmem [0:2047];
    always @(posedge clk) begin
        if (reset) begin
            dmem[5]    <= 32'h0000_00A5;
            dmem[2047] <= 32'h0000_7FF7;
            for (int k = 0; k < 4; k++) begin
                dmem[20+k] <= 32'h100 + 32'(k);
                dmem[30+k] <= 32'h200 + 32'(k);
            end
        end
        if (mem_write) dmem[mem_addr[10:0]] <= mem_wdata;
        mem_rdata <= mem_read ? dmem[mem_addr[10:0]] : 32'hDEAD_BEEF;
    end

    typedef struct {
        logic        kind;   // 0 = issue (gnt), 1 = response (rvalid/err)
        logic        id;
        logic        err;
        logic        mw;
        logic        mr;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic exp_issue(input logic id, input logic mw, input logic mr,
                             input logic [31:0] a, input logic e);
        exp_t x;
        x.kind = 1'b0; x.id = id; x.err = e; x.mw = mw; x.mr = mr;
        x.addr = a; x.rdata = '0;
        exp_q.push_back(x);
    endtask

    task automatic exp_resp(input logic id, input logic [31:0] d, input logic e);
        exp_t x;
        x.kind = 1'b1; x.id = id; x.err = e; x.mw = 1'b0; x.mr = 1'b0;
        x.addr = '0; x.rdata = d;
        exp_q.push_back(x);
    endtask

    // Monitor: pops one expected record for every DUT output event.
    initial begin : monitor
        exp_t        e;
        logic        ev_kind, ev_id, err_x, quiet, lat_ok, mw_prev;
        logic [31:0] rdata_x;
        logic [63:0] act_v, exp_v;
        int          last_issue;
        mw_prev    = 1'b0;
        last_issue = -10;
        forever begin
            @(negedge clk);
            if (mem_write) begin
                checks++;
                if (mem_read || mw_prev) begin
                    errors++;
                    $display("FAIL strobe: actual mem_write=1 mem_read=%0b prev_write=%0b, required mem_read=0 prev_write=0",
                             mem_read, mw_prev);
                end
            end
            mw_prev = mem_write;
            if (m0_gnt | m1_gnt | m0_rvalid | m1_rvalid | m0_err | m1_err) begin
                ev_kind = !(m0_gnt | m1_gnt);
                ev_id   = ev_kind ? (m1_rvalid | m1_err) : m1_gnt;
                err_x   = ev_id ? m1_err : m0_err;
                rdata_x = ev_id ? m1_rdata : m0_rdata;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: actual kind=%0b id=%0b at cycle %0d, required no event",
                             ev_kind, ev_id, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (!ev_kind) begin
                        quiet = ev_id ? (!m0_gnt && !m0_err) : (!m1_gnt && !m1_err);
                        quiet = quiet && !m0_rvalid && !m1_rvalid;
                        act_v = 64'({ev_kind, ev_id, err_x, mem_write, mem_read, mem_addr, quiet});
                        exp_v = 64'({e.kind, e.id, e.err, e.mw, e.mr, e.addr, 1'b1});
                        last_issue = cyc;
                    end else begin
                        quiet = ev_id ? (!m0_rvalid && !m0_err && m0_rdata == 0)
                                      : (!m1_rvalid && !m1_err && m1_rdata == 0);
                        quiet = quiet && !m0_gnt && !m1_gnt && (ev_id ? m1_rvalid : m0_rvalid);
                        lat_ok = (cyc == last_issue + 1);
                        act_v = 64'({ev_kind, ev_id, err_x, rdata_x, lat_ok, quiet});
                        exp_v = 64'({e.kind, e.id, e.err, e.rdata, 1'b1, 1'b1});
                    end
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL %s at cycle %0d: actual %h, required %h",
                                 ev_kind ? "response" : "issue", cyc, act_v, exp_v);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_m(input logic id, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (id) begin
            m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d;
        end
    endtask

    // One request: raise req, wait (bounded) for gnt, drop req after that edge.
    task automatic req_one(input logic id, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output int lat);
        logic seen;
        seen = 1'b0;
        lat  = -1;
        set_m(id, 1'b1, w, a, d);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (id ? m1_gnt : m0_gnt) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: actual no m%0d_gnt in 40 cycles, required a grant", id);
        end
        @(posedge clk);
        #1;
        set_m(id, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string name);
        logic [5:0] pulses;
        pulses = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err};
        checks++;
        if (pulses !== 6'b0 || mem_write !== 1'b0 || mem_read !== 1'b0 ||
            mem_addr !== 32'h0 || mem_wdata !== 32'h0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s: actual pulses=%b mw=%0b mr=%0b addr=%h wdata=%h, required all zero",
                     name, pulses, mem_write, mem_read, mem_addr, mem_wdata);
        end
    endtask

    int lat;
    int n0, n1;
    int gc [3];
    logic g0, g1;

    initial begin : stim
        reset = 1'b1;
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);
        @(negedge clk);
        check_quiet("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // 1: m0 read 5, gnt one cycle after request, data next cycle
        exp_issue(1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
        exp_resp(1'b0, 32'h0000_00A5, 1'b0);
        req_one(1'b0, 1'b0, 32'd5, 32'h0, lat);
        checks++;
        if (lat != 1) begin
            errors++;
            $display("FAIL gnt_latency: actual %0d, required 1", lat);
        end
        idle(2);

        // 2: m1 write 10, then m0 reads it back
        exp_issue(1'b1, 1'b1, 1'b0, 32'd10, 1'b0);
        req_one(1'b1, 1'b1, 32'd10, 32'h1234, lat);
        exp_issue(1'b0, 1'b0, 1'b1, 32'd10, 1'b0);
        exp_resp(1'b0, 32'h1234, 1'b0);
        req_one(1'b0, 1'b0, 32'd10, 32'h0, lat);
        idle(2);

        // 4: range boundaries
        exp_issue(1'b0, 1'b0, 1'b1, 32'd2047, 1'b0);
        exp_resp(1'b0, 32'h0000_7FF7, 1'b0);
        req_one(1'b0, 1'b0, 32'd2047, 32'h0, lat);
        exp_issue(1'b0, 1'b0, 1'b0, 32'd2048, 1'b0);
        exp_resp(1'b0, 32'h0, 1'b1);
        req_one(1'b0, 1'b0, 32'd2048, 32'h0, lat);
        exp_issue(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1);
        req_one(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h5555, lat);
        exp_issue(1'b1, 1'b0, 1'b1, 32'd5, 1'b0);
        exp_resp(1'b1, 32'h0000_00A5, 1'b0);
        req_one(1'b1, 1'b0, 32'd5, 32'h0, lat);
        idle(2);

        // 3: both read continuously, 4 reads each
        for (int g = 0; g < 8; g++) begin
            logic gid;
            int   k;
`ifdef DMEM_ARB_RR_EN
            gid = g[0];
            k   = g / 2;
`else
            gid = (g >= 4);
            k   = g % 4;
`endif
            exp_issue(gid, 1'b0, 1'b1, (gid ? 32'd30 : 32'd20) + 32'(k), 1'b0);
            exp_resp(gid, (gid ? 32'h200 : 32'h100) + 32'(k), 1'b0);
        end
        n0 = 0;
        n1 = 0;
        set_m(1'b0, 1'b1, 1'b0, 32'd20, 32'h0);
        set_m(1'b1, 1'b1, 1'b0, 32'd30, 32'h0);
        for (int i = 0; i < 80 && (n0 < 4 || n1 < 4); i++) begin
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            @(posedge clk);
            #1;
            if (g0) begin
                n0++;
                if (n0 == 4) set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                else         m0_addr = 32'd20 + 32'(n0);
            end
            if (g1) begin
                n1++;
                if (n1 == 4) set_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
                else         m1_addr = 32'd30 + 32'(n1);
            end
        end
        checks++;
        if (n0 != 4 || n1 != 4) begin
            errors++;
            $display("FAIL contention_grants: actual m0=%0d m1=%0d, required 4 and 4", n0, n1);
        end
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_m(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // 6: m0 back-to-back writes with req held
        for (int k = 0; k < 3; k++) exp_issue(1'b0, 1'b1, 1'b0, 32'd40 + 32'(k), 1'b0);
        n0 = 0;
        gc[0] = 0; gc[1] = 0; gc[2] = 0;
        set_m(1'b0, 1'b1, 1'b1, 32'd40, 32'hC000);
        for (int i = 0; i < 40 && n0 < 3; i++) begin
            @(negedge clk);
            if (m0_gnt) begin
                gc[n0] = cyc;
                n0++;
                @(posedge clk);
                #1;
                m0_addr  = 32'd40 + 32'(n0);
                m0_wdata = 32'hC000 + 32'(n0);
            end
        end
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if (n0 != 3 || gc[1] - gc[0] != 2 || gc[2] - gc[1] != 2) begin
            errors++;
            $display("FAIL b2b_write_spacing: actual grants=%0d gaps=%0d,%0d, required 3 grants gaps 2,2",
                     n0, gc[1] - gc[0], gc[2] - gc[1]);
        end
        exp_issue(1'b0, 1'b0, 1'b1, 32'd42, 1'b0);
        exp_resp(1'b0, 32'hC002, 1'b0);
        req_one(1'b0, 1'b0, 32'd42, 32'h0, lat);
        idle(2);

        // 5: reset during the response cycle of an m0 read
        exp_issue(1'b0, 1'b0, 1'b1, 32'd5, 1'b0);
        set_m(1'b0, 1'b1, 1'b0, 32'd5, 32'h0);
        g0 = 1'b0;
        for (int i = 0; i < 40 && !g0; i++) begin
            @(negedge clk);
            g0 = m0_gnt;
        end
        @(posedge clk);
        #1;
        set_m(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (!g0 || m0_rvalid !== 1'b0 || m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_in_resp: actual gnt_seen=%0b rvalid=%0b rdata=%h, required 1 0 0",
                     g0, m0_rvalid, m0_rdata);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");
        exp_issue(1'b1, 1'b0, 1'b1, 32'd10, 1'b0);
        exp_resp(1'b1, 32'h1234, 1'b0);
        req_one(1'b1, 1'b0, 32'd10, 32'h0, lat);
        idle(5);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual %0d pending, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
